// File: rtl/screen_pkg.sv
// Shared screen encodings, keycodes and pick geometry for screen_sequencer and color_mapper.
package screen_pkg;

    typedef enum logic [2:0] {
        TITLE = 3'b000,
        PLAY1 = 3'b001,
        PLAY2 = 3'b010,
        PAUSE = 3'b011,
        WIN   = 3'b111
    } screen_t;

    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam logic [7:0] KEY_ESC   = 8'h29;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_D     = 8'h07;

    localparam int LEVEL_FRAMES = 600;
    localparam int WIN_FRAMES   = 180;
    localparam int STEP         = 4;

    localparam logic [9:0] X_MIN   = 10'd8;
    localparam logic [9:0] X_MAX   = 10'd631;
    localparam logic [9:0] Y_MIN   = 10'd8;
    localparam logic [9:0] Y_MAX   = 10'd471;
    localparam logic [9:0] PICK_X0 = 10'd310;
    localparam logic [9:0] PICK_Y0 = 10'd240;

    localparam logic [9:0] LEVEL_LAST = 10'(LEVEL_FRAMES - 1);
    localparam logic [9:0] WIN_LAST   = 10'(WIN_FRAMES - 1);
    localparam logic [9:0] CNT_MAX    = 10'h3FF;

    // Signed 11-bit step so an underflow below lo clamps instead of wrapping.
    function automatic logic [9:0] step_clamp(input logic [9:0] pos, input logic neg,
                                              input logic [9:0] lo, input logic [9:0] hi);
        logic signed [10:0] p;
        logic signed [10:0] d;
        logic signed [10:0] nxt;
        p   = signed'({1'b0, pos});
        d   = 11'(STEP);
        nxt = neg ? (p - d) : (p + d);
        if (nxt < signed'({1'b0, lo}))
            return lo;
        else if (nxt > signed'({1'b0, hi}))
            return hi;
        else
            return nxt[9:0];
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Registers VS and emits a one-cycle pulse on each rising edge, one cycle after it is seen.
module frame_tick_gen (
    input  logic clk,
    input  logic reset,
    input  logic vs,
    output logic frame_tick
);

    logic vs_q;

    // VS idles high, so the history starts high to avoid a tick on reset release.
    always_ff @(posedge clk) begin
        if (reset) begin
            vs_q       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vs_q       <= vs;
            frame_tick <= vs & ~vs_q;
        end
    end

endmodule

// File: rtl/screen_sequencer.sv
// Game-flow FSM driving currScreen, PickX and PickY from keycodes and frame ticks.
// Optional attract/demo mode is built when SCREEN_SEQ_ATTRACT_EN is defined.
module screen_sequencer
    import screen_pkg::*;
(
    input  logic       CLK,
    input  logic       Reset,
    input  logic       VS,
    input  logic [7:0] keycode,
    output logic [2:0] currScreen,
    output logic [9:0] PickX,
    output logic [9:0] PickY,
    output logic [9:0] frame_cnt
);

    screen_t    state;
    screen_t    resume;
    logic [7:0] keycode_q;
    logic       tick;
    logic       press_enter;
    logic       press_esc;
    logic [9:0] y_up;
    logic [9:0] y_down;
    logic [9:0] move_x;
    logic [9:0] move_y;

    frame_tick_gen u_frame_tick_gen (
        .clk       (CLK),
        .reset     (Reset),
        .vs        (VS),
        .frame_tick(tick)
    );

    assign currScreen  = state;
    assign press_enter = (keycode == KEY_ENTER) && (keycode_q != KEY_ENTER);
    assign press_esc   = (keycode == KEY_ESC) && (keycode_q != KEY_ESC);
    assign y_up        = step_clamp(PickY, 1'b1, Y_MIN, Y_MAX);
    assign y_down      = step_clamp(PickY, 1'b0, Y_MIN, Y_MAX);

    // Direction keys are level-sensitive; only one keycode can be present at a time.
    always_comb begin
        move_x = PickX;
        move_y = PickY;
        if (keycode == KEY_W)
            move_y = y_up;
        else if (keycode == KEY_S)
            move_y = y_down;
        if (keycode == KEY_A)
            move_x = step_clamp(PickX, 1'b1, X_MIN, X_MAX);
        else if (keycode == KEY_D)
            move_x = step_clamp(PickX, 1'b0, X_MIN, X_MAX);
    end

`ifdef SCREEN_SEQ_ATTRACT_EN
    logic [8:0] idle_cnt;
    logic       demo;
    logic       demo_down;
    logic       attract_go;

    assign attract_go = (state == TITLE) && tick && (keycode == 8'h00) && (idle_cnt == 9'h1FF);

    always_ff @(posedge CLK) begin
        if (Reset || (state != TITLE) || (keycode != 8'h00))
            idle_cnt <= 9'd0;
        else if (tick)
            idle_cnt <= idle_cnt + 9'd1;
    end
`endif

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= TITLE;
            resume    <= PLAY1;
            keycode_q <= 8'h00;
            frame_cnt <= 10'd0;
            PickX     <= PICK_X0;
            PickY     <= PICK_Y0;
`ifdef SCREEN_SEQ_ATTRACT_EN
            demo      <= 1'b0;
            demo_down <= 1'b0;
`endif
        end else begin
            keycode_q <= keycode;
            case (state)
                TITLE: begin
                    if (press_enter) begin
                        state     <= PLAY1;
                        frame_cnt <= 10'd0;
                        PickX     <= PICK_X0;
                        PickY     <= PICK_Y0;
                    end
`ifdef SCREEN_SEQ_ATTRACT_EN
                    else if (attract_go) begin
                        state     <= PLAY1;
                        demo      <= 1'b1;
                        demo_down <= 1'b0;
                        frame_cnt <= 10'd0;
                        PickX     <= PICK_X0;
                        PickY     <= PICK_Y0;
                    end
`endif
                    else if (tick && (frame_cnt != CNT_MAX))
                        frame_cnt <= frame_cnt + 10'd1;
                end
                PLAY1: begin
`ifdef SCREEN_SEQ_ATTRACT_EN
                    if (demo) begin
                        if (keycode != 8'h00) begin
                            state     <= TITLE;
                            demo      <= 1'b0;
                            frame_cnt <= 10'd0;
                            PickX     <= PICK_X0;
                            PickY     <= PICK_Y0;
                        end else if (tick) begin
                            PickY <= demo_down ? y_down : y_up;
                            if (demo_down && (y_down == Y_MAX))
                                demo_down <= 1'b0;
                            else if (!demo_down && (y_up == Y_MIN))
                                demo_down <= 1'b1;
                        end
                    end else
`endif
                    if (press_esc) begin
                        state  <= PAUSE;
                        resume <= PLAY1;
                    end else if (tick) begin
                        if (frame_cnt == LEVEL_LAST) begin
                            state     <= PLAY2;
                            frame_cnt <= 10'd0;
                        end else begin
                            frame_cnt <= frame_cnt + 10'd1;
                            PickY     <= move_y;
                        end
                    end
                end
                PLAY2: begin
                    if (press_esc) begin
                        state  <= PAUSE;
                        resume <= PLAY2;
                    end else if (tick) begin
                        if (frame_cnt == LEVEL_LAST) begin
                            state     <= WIN;
                            frame_cnt <= 10'd0;
                        end else begin
                            frame_cnt <= frame_cnt + 10'd1;
                            PickX     <= move_x;
                            PickY     <= move_y;
                        end
                    end
                end
                PAUSE: begin
                    if (press_esc) begin
                        state <= resume;
                    end else if (press_enter) begin
                        state     <= TITLE;
                        frame_cnt <= 10'd0;
                        PickX     <= PICK_X0;
                        PickY     <= PICK_Y0;
                    end
                end
                WIN: begin
                    if (press_enter || (tick && (frame_cnt == WIN_LAST))) begin
                        state     <= TITLE;
                        frame_cnt <= 10'd0;
                        PickX     <= PICK_X0;
                        PickY     <= PICK_Y0;
                    end else if (tick) begin
                        frame_cnt <= frame_cnt + 10'd1;
                    end
                end
                default: begin
                    state     <= TITLE;
                    frame_cnt <= 10'd0;
                    PickX     <= PICK_X0;
                    PickY     <= PICK_Y0;
                end
            endcase
        end
    end

endmodule
